reg_issue: RTL

REG_ISSUE -- requirements
Module: reg_issue

---
 rtl/core_pkg.sv | 38 +++
 rtl/reg_issue_regfile.sv | 41 ++++
 rtl/reg_issue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared constants, FSM state type and legality decode for the R-type issue block.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package core_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Only the ADD/SUB/XOR/OR/AND subset of OP is accepted; funct7 ALT is SUB only.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7);
    logic ok;
    ok = 1'b0;
    if (opcode == OPC_OP) begin
      case (funct3)
        F3_ADD_SUB:            ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        F3_XOR, F3_OR, F3_AND: ok = (funct7 == F7_BASE);
        default:               ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_issue_regfile.sv
// Architectural register file: two operand read ports, one debug read port, one write port.
// Latency: reads are combinational; a write lands at the end of the cycle it is presented.
// Backpressure: none; the write port is always accepted, x0 writes are dropped.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1_i,
  output logic [XLEN-1:0] rd1_o,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd2_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Synchronous clear on reset, otherwise a single write per cycle that skips x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // x0 is forced to zero on every read port regardless of storage contents.
  always_comb begin
    rd1_o      = (ra1_i      == 5'd0) ? '0 : regs_q[ra1_i];
    rd2_o      = (ra2_i      == 5'd0) ? '0 : regs_q[ra2_i];
    dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];
  end

endmodule

// File: rtl/reg_issue.sv
// Three-state issue of R-type ALU ops: read operands, present to an external registered ALU, write back.
// Latency: 3 cycles per instruction (accept, EXEC, WB); result written at the end of WB.
// Backpressure: instr_ready is high only in IDLE, so at most one instruction every third cycle.
module reg_issue
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_rd,
  output logic            wb_valid,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_e          state_q;
  logic            ready_q;
  logic            wb_valid_q;
  logic            illegal_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;
  logic            hs;
  logic            legal;

  assign hs    = instr_valid && ready_q;
  assign legal = is_legal(instr[6:0], instr[14:12], instr[31:25]);

  regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .ra1_i      (instr[19:15]),
    .rd1_o      (rs1_d),
    .ra2_i      (instr[24:20]),
    .rd2_o      (rs2_d),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (wb_valid_q),
    .wa_i       (rd_q),
    .wd_i       (alu_rd)
  );

  // Issue FSM with registered ready/valid/illegal; operand latches double as the ALU outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            if (legal) begin
              funct3_q <= instr[14:12];
              funct7_q <= instr[31:25];
              rd_q     <= instr[11:7];
              rs1_q    <= rs1_d;
              rs2_q    <= rs2_d;
              state_q  <= ST_EXEC;
              ready_q  <= 1'b0;
            end else begin
              // Rejected words never leave IDLE; ready stays up for the next offer.
              illegal_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state_q    <= ST_WB;
          wb_valid_q <= 1'b1;
        end
        ST_WB: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign illegal     = illegal_q;
  assign alu_funct3  = funct3_q;
  assign alu_funct7  = funct7_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = rd_q;
  assign wb_data     = alu_rd;

endmodule
